fetch_sequencer: RTL and testbench

- Instruction fetch/sequencing stage for the 8-bit-address, 12-bit-instruction CPU.
- Drives the program-memory address and latches the returned instruction into an instruction register.
- Resolves control flow locally: JMP, BAN and STP are handled here and never issued downstream.
- Issues all remaining instructions to the execute stage over a valid/ready handshake.

---
 rtl/fetch_sequencer.sv | 115 +++++++++++
 tb/tb_fetch_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch/decode/issue sequencer: resolves JMP, BAN and STP locally and issues the rest over valid/ready.
// Optional build macro ILLEGAL_TRAP_EN: undefined opcodes halt with illegal=1 instead of being issued.
module fetch_sequencer #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [7:0]  addr,
   input  logic [11:0] ins,
   input  logic        acc_neg,
   input  logic        ir_ready,
   output logic        ir_valid,
   output logic [11:0] ir,
   output logic [3:0]  opcode,
   output logic [7:0]  operand,
   output logic [7:0]  pc,
   output logic        halted,
   output logic        illegal
);

   typedef enum logic [1:0] {
      st_fetch  = 2'd0,
      st_decode = 2'd1,
      st_issue  = 2'd2,
      st_halt   = 2'd3
   } state_t;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_STA = 4'b0010;
   localparam logic [3:0] OP_LDA = 4'b0100;
   localparam logic [3:0] OP_JMP = 4'b1010;
   localparam logic [3:0] OP_BAN = 4'b1100;
   localparam logic [3:0] OP_SHR = 4'b1101;
   localparam logic [3:0] OP_STP = 4'b1111;

   state_t      state, state_next;
   logic [7:0]  pc_next;
   logic [11:0] ir_next;

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q, illegal_next;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= st_fetch;
         pc    <= RESET_PC;
         ir    <= 12'h000;
`ifdef ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state <= state_next;
         pc    <= pc_next;
         ir    <= ir_next;
`ifdef ILLEGAL_TRAP_EN
         illegal_q <= illegal_next;
`endif
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      ir_next    = ir;
`ifdef ILLEGAL_TRAP_EN
      illegal_next = illegal_q;
`endif
      case (state)
         st_fetch: begin
            ir_next    = ins;
            pc_next    = pc + 8'd1;
            state_next = st_decode;
         end
         st_decode: begin
            case (opcode)
               OP_JMP: begin
                  pc_next    = operand;
                  state_next = st_fetch;
               end
               OP_BAN: begin
                  if (acc_neg) pc_next = operand;
                  state_next = st_fetch;
               end
               OP_STP:                         state_next = st_halt;
               OP_ADD, OP_STA, OP_LDA, OP_SHR: state_next = st_issue;
               default: begin
`ifdef ILLEGAL_TRAP_EN
                  state_next   = st_halt;
                  illegal_next = 1'b1;
`else
                  state_next = st_issue;
`endif
               end
            endcase
         end
         st_issue: begin
            if (ir_ready) state_next = st_fetch;
         end
         default: state_next = st_halt;
      endcase
   end

   assign addr     = pc;
   assign opcode   = ir[11:8];
   assign operand  = ir[7:0];
   assign ir_valid = (state == st_issue);
   assign halted   = (state == st_halt);
`ifdef ILLEGAL_TRAP_EN
   assign illegal  = illegal_q;
`else
   assign illegal  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer: a per-cycle vector table for a short program
// plus hand-written sequences for jumps, branches, stalls, pc wrap, undefined opcodes and reset.
module tb_fetch_sequencer;

   logic        clk;
   logic        rst_n;
   logic [7:0]  addr;
   logic [11:0] ins;
   logic        acc_neg;
   logic        ir_ready;
   logic        ir_valid;
   logic [11:0] ir;
   logic [3:0]  opcode;
   logic [7:0]  operand;
   logic [7:0]  pc;
   logic        halted;
   logic        illegal;

   logic [11:0] mem [256];
   int testsRun = 0;
   int failCount = 0;
   int xferCount = 0;

   typedef struct {
      logic        rdy;
      logic        expValid;
      logic [11:0] expIr;
      logic [7:0]  expPc;
      logic        expHalted;
   } vecT;

   vecT vecs [9];

   fetch_sequencer #(.RESET_PC(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .ins(ins), .acc_neg(acc_neg),
      .ir_ready(ir_ready), .ir_valid(ir_valid), .ir(ir), .opcode(opcode),
      .operand(operand), .pc(pc), .halted(halted), .illegal(illegal)
   );

   assign ins = mem[addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts completed handshakes so stall tests can check exactly one transfer happened.
   always @(posedge clk) begin
      if (rst_n && ir_valid && ir_ready) xferCount <= xferCount + 1;
   end

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic clearMem();
      for (int i = 0; i < 256; i++) mem[i] = 12'hF00;
   endtask

   // Holds reset across a clock edge, checks the reset state, then releases at a falling edge.
   task automatic applyStimulus(input logic rdy, input logic neg);
      @(negedge clk);
      rst_n = 1'b0;
      ir_ready = rdy;
      acc_neg = neg;
      #1;
      checkOutput("reset ir_valid", {15'd0, ir_valid}, 16'd0);
      checkOutput("reset pc", {8'd0, pc}, 16'h0000);
      checkOutput("reset halted", {15'd0, halted}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      int startX;
      int edges;
      rst_n = 1'b0;
      ir_ready = 1'b0;
      acc_neg = 1'b0;

      // Program: LDA 01, ADD 02, STP with ir_ready held high.
      vecs[0] = '{1'b1, 1'b0, 12'h401, 8'h01, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 12'h401, 8'h01, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 12'h401, 8'h01, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 12'h002, 8'h02, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 12'h002, 8'h02, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 12'h002, 8'h02, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 12'hF00, 8'h03, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 12'hF00, 8'h03, 1'b1};
      vecs[8] = '{1'b1, 1'b0, 12'hF00, 8'h03, 1'b1};

      clearMem();
      mem[0] = 12'h401; mem[1] = 12'h002; mem[2] = 12'hF00;
      applyStimulus(1'b1, 1'b0);
      checkOutput("first addr", {8'd0, addr}, 16'h0000);
      for (int i = 0; i < 9; i++) begin
         ir_ready = vecs[i].rdy;
         step();
         checkOutput($sformatf("prog1 c%0d valid", i), {15'd0, ir_valid}, {15'd0, vecs[i].expValid});
         checkOutput($sformatf("prog1 c%0d ir", i), {4'd0, ir}, {4'd0, vecs[i].expIr});
         checkOutput($sformatf("prog1 c%0d pc", i), {8'd0, pc}, {8'd0, vecs[i].expPc});
         checkOutput($sformatf("prog1 c%0d halted", i), {15'd0, halted}, {15'd0, vecs[i].expHalted});
      end

      // JMP 05 then ADD 07: first ir_valid after the fourth edge, none before.
      clearMem();
      mem[0] = 12'hA05; mem[5] = 12'h007; mem[6] = 12'hF00;
      applyStimulus(1'b1, 1'b0);
      edges = 0;
      while (!ir_valid && edges < 20) begin
         step();
         edges++;
      end
      checkOutput("jmp latency", edges[15:0], 16'd4);
      checkOutput("jmp first ir", {4'd0, ir}, 16'h0007);
      checkOutput("jmp pc", {8'd0, pc}, 16'h0006);

      // BAN 1C at address 3, taken and not taken.
      for (int n = 0; n < 2; n++) begin
         logic validSeen;
         clearMem();
         mem[0] = 12'hA03; mem[3] = 12'hC1C;
         applyStimulus(1'b1, (n == 0));
         validSeen = 1'b0;
         for (int c = 0; c < 4; c++) begin
            step();
            validSeen = validSeen | ir_valid;
         end
         checkOutput($sformatf("ban neg=%0d pc", (n == 0)), {8'd0, pc}, (n == 0) ? 16'h001C : 16'h0004);
         checkOutput($sformatf("ban neg=%0d no valid", (n == 0)), {15'd0, validSeen}, 16'd0);
      end

      // SHR stalled for 4 cycles, then accepted once.
      clearMem();
      mem[0] = 12'hD00; mem[1] = 12'hF00;
      applyStimulus(1'b0, 1'b0);
      step(); step();
      startX = xferCount;
      for (int c = 0; c < 4; c++) begin
         checkOutput($sformatf("stall c%0d valid", c), {15'd0, ir_valid}, 16'd1);
         checkOutput($sformatf("stall c%0d ir", c), {4'd0, ir}, 16'h0D00);
         checkOutput($sformatf("stall c%0d pc", c), {8'd0, pc}, 16'h0001);
         step();
      end
      ir_ready = 1'b1;
      step();
      checkOutput("stall accept valid", {15'd0, ir_valid}, 16'd0);
      checkOutput("stall accept pc", {8'd0, pc}, 16'h0001);
      step(); step(); step();
      checkOutput("stall xfers", 16'(xferCount - startX), 16'd1);
      checkOutput("stall halted", {15'd0, halted}, 16'd1);
      checkOutput("stall final pc", {8'd0, pc}, 16'h0002);

      // JMP FF with ADD 00 at FF: fetch reads FF, pc wraps to 00.
      clearMem();
      mem[0] = 12'hAFF; mem[255] = 12'h000;
      applyStimulus(1'b1, 1'b0);
      step(); step();
      checkOutput("wrap addr", {8'd0, addr}, 16'h00FF);
      step();
      checkOutput("wrap pc", {8'd0, pc}, 16'h0000);
      checkOutput("wrap ir", {4'd0, ir}, 16'h0000);
      step();
      checkOutput("wrap valid", {15'd0, ir_valid}, 16'd1);

      // Undefined opcode 0110 at address 0.
      clearMem();
      mem[0] = 12'h600;
      applyStimulus(1'b0, 1'b0);
      step(); step();
`ifdef ILLEGAL_TRAP_EN
      checkOutput("undef halted", {15'd0, halted}, 16'd1);
      checkOutput("undef illegal", {15'd0, illegal}, 16'd1);
      checkOutput("undef pc", {8'd0, pc}, 16'h0001);
      checkOutput("undef ir", {4'd0, ir}, 16'h0600);
`else
      checkOutput("undef valid", {15'd0, ir_valid}, 16'd1);
      checkOutput("undef ir", {4'd0, ir}, 16'h0600);
      checkOutput("undef illegal", {15'd0, illegal}, 16'd0);
`endif

      // Reset pulsed mid-ISSUE drops ir_valid without waiting for a clock edge.
      clearMem();
      mem[0] = 12'hD00;
      applyStimulus(1'b0, 1'b0);
      step(); step();
      checkOutput("midreset pre valid", {15'd0, ir_valid}, 16'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset valid", {15'd0, ir_valid}, 16'd0);
      checkOutput("midreset pc", {8'd0, pc}, 16'h0000);
      checkOutput("midreset ir", {4'd0, ir}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("resume addr", {8'd0, addr}, 16'h0000);
      step();
      checkOutput("resume ir", {4'd0, ir}, 16'h0D00);
      checkOutput("resume pc", {8'd0, pc}, 16'h0001);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
